// File: rtl/if_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and the
// instruction memory (slave): a request/ready handshake with a word address
// going out and the instruction word coming back.
interface if_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Owns the PC, fetches over the imem req/ready
// handshake and presents pc_four_1/instr_1 together with the ifwrite/if_flush
// controls for the IF/ID pipeline register. The hazard unit's pcwrite stalls
// the stage, and branch (EX) or jump (ID) requests redirect it.
// Optional build macro IF_ALIGN_CHECK_EN: when defined, a misaligned redirect
// target sets the sticky align_err flag; when undefined, align_err is tied 0.
// In both builds the low two target bits are forced to zero.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pcwrite,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   if_fetch_if.master  imem,
   output logic [31:0] pc_four_1,
   output logic [31:0] instr_1,
   output logic        ifwrite,
   output logic        if_flush,
   output logic        align_err
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_VALID = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [31:0] pc;
   logic [31:0] pc_n;
   logic [31:0] drain_addr;
   logic [31:0] drain_addr_n;
   logic [31:0] pc_four_n;
   logic [31:0] instr_n;
   logic        instr_valid;
   logic        valid_n;
   logic        req_c;
   logic [31:0] addr_c;

   logic        redirect;
   logic [31:0] target_raw;
   logic [31:0] target;
   logic [31:0] pc_plus4;

   assign redirect   = branch_taken | jump;
   assign target_raw = branch_taken ? branch_target : jump_target;
   assign target     = target_raw & ~32'h0000_0003;
   assign pc_plus4   = pc + 32'd4;

   // Next-state, next-PC and memory request decode for the fetch FSM.
   always_comb begin
      state_n      = state;
      pc_n         = pc;
      drain_addr_n = drain_addr;
      pc_four_n    = pc_four_1;
      instr_n      = instr_1;
      valid_n      = instr_valid;
      req_c        = 1'b0;
      addr_c       = pc;
      case (state)
         S_REQ: begin
            req_c = 1'b1;
            if (redirect) begin
               pc_n = target;
               if (!imem.imem_ready) begin
                  drain_addr_n = pc;
                  state_n      = S_DRAIN;
               end
            end else if (imem.imem_ready) begin
               instr_n   = imem.imem_rdata;
               pc_four_n = pc_plus4;
               pc_n      = pc_plus4;
               valid_n   = 1'b1;
               state_n   = S_VALID;
            end
         end
         S_VALID: begin
            if (redirect) begin
               valid_n = 1'b0;
               pc_n    = target;
               state_n = S_REQ;
            end else if (pcwrite) begin
               req_c = 1'b1;
               if (imem.imem_ready) begin
                  instr_n   = imem.imem_rdata;
                  pc_four_n = pc_plus4;
                  pc_n      = pc_plus4;
               end else begin
                  valid_n = 1'b0;
                  state_n = S_REQ;
               end
            end
         end
         S_DRAIN: begin
            req_c  = 1'b1;
            addr_c = drain_addr;
            if (redirect) begin
               pc_n = target;
            end
            if (imem.imem_ready) begin
               state_n = S_REQ;
            end
         end
         default: begin
            valid_n = 1'b0;
            state_n = S_REQ;
         end
      endcase
   end

   // State, PC and IF/ID holding registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_REQ;
         pc          <= RESET_PC;
         drain_addr  <= RESET_PC;
         pc_four_1   <= 32'd0;
         instr_1     <= 32'd0;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         drain_addr  <= drain_addr_n;
         pc_four_1   <= pc_four_n;
         instr_1     <= instr_n;
         instr_valid <= valid_n;
      end
   end

   assign imem.imem_req  = req_c & ~rst;
   assign imem.imem_addr = addr_c;
   assign ifwrite        = ~rst & instr_valid & pcwrite & ~redirect;
   assign if_flush       = ~rst & (redirect | (pcwrite & ~instr_valid));

`ifdef IF_ALIGN_CHECK_EN
   logic align_err_q;

   // Sticky flag recording any redirect to a non-word-aligned target.
   always_ff @(posedge clk) begin
      if (rst) begin
         align_err_q <= 1'b0;
      end else if (redirect && (target_raw[1:0] != 2'b00)) begin
         align_err_q <= 1'b1;
      end
   end

   assign align_err = align_err_q;
`else
   assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch. A behavioural instruction memory with a
// programmable number of wait states answers the fetch requests; every fetch
// the stage should keep is pushed to a scoreboard, and each ifwrite pops it
// and compares the IF/ID outputs.
module tb_if_fetch;

   typedef struct packed {
      logic [31:0] pc_four;
      logic [31:0] instr;
   } fetch_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        pcwrite;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic [31:0] pc_four_1;
   logic [31:0] instr_1;
   logic        ifwrite;
   logic        if_flush;
   logic        align_err;

   int          checks = 0;
   int          errors = 0;
   int          mem_wait = 0;
   int          wait_cnt = 0;
   fetch_t      sb[$];
   fetch_t      exp_e;
   logic        exp_align;

   if_fetch_if bus ();

   if_fetch #(.RESET_PC(32'h0000_3000)) dut (
      .clk           (clk),
      .rst           (rst),
      .pcwrite       (pcwrite),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .imem          (bus),
      .pc_four_1     (pc_four_1),
      .instr_1       (instr_1),
      .ifwrite       (ifwrite),
      .if_flush      (if_flush),
      .align_err     (align_err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Instruction memory: answers after mem_wait cycles of a held request.
   always_comb begin
      bus.imem_ready = bus.imem_req && (wait_cnt >= mem_wait);
      bus.imem_rdata = bus.imem_ready ? instr_of(bus.imem_addr) : 32'hBAD0_BAD0;
   end

   // Wait-state counter of the memory model.
   always @(posedge clk) begin
      if (!bus.imem_req || bus.imem_ready) wait_cnt <= 0;
      else                                 wait_cnt <= wait_cnt + 1;
   end

   // Scoreboard consumer plus the ifwrite/if_flush exclusivity check.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (ifwrite && if_flush) begin
            errors++;
            $display("[TB] FAIL excl ifwrite=%0b if_flush=%0b, required not both 1", ifwrite, if_flush);
         end
         if (ifwrite) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("[TB] FAIL sb_empty ifwrite=1 with pc_four_1=%h, required no write", pc_four_1);
            end else begin
               exp_e = sb.pop_front();
               if (pc_four_1 !== exp_e.pc_four || instr_1 !== exp_e.instr) begin
                  errors++;
                  $display("[TB] FAIL sb_data pc_four_1=%h instr_1=%h, required %h %h",
                           pc_four_1, instr_1, exp_e.pc_four, exp_e.instr);
               end
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst     = 1'b1;
      pcwrite = 1'b1;
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req got %b want 0", bus.imem_req); end
      checks++; if (ifwrite !== 1'b0) begin errors++; $display("[TB] FAIL rst_ifwrite got %b want 0", ifwrite); end
      checks++; if (if_flush !== 1'b0) begin errors++; $display("[TB] FAIL rst_flush got %b want 0", if_flush); end
      checks++; if (pc_four_1 !== 32'd0) begin errors++; $display("[TB] FAIL rst_pc4 got %h want 0", pc_four_1); end
      checks++; if (instr_1 !== 32'd0) begin errors++; $display("[TB] FAIL rst_instr got %h want 0", instr_1); end
      checks++; if (align_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_align got %b want 0", align_err); end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_sequential;
      logic [31:0] a;
      for (int i = 0; i < 4; i++) begin
         a = 32'h0000_3000 + 32'(4 * i);
         @(negedge clk);
         checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== a) begin errors++; $display("[TB] FAIL seq_addr got %b/%h want 1/%h", bus.imem_req, bus.imem_addr, a); end
         checks++; if (ifwrite !== (i > 0)) begin errors++; $display("[TB] FAIL seq_ifwrite cycle %0d got %b want %b", i, ifwrite, (i > 0)); end
         checks++; if (if_flush !== (i == 0)) begin errors++; $display("[TB] FAIL seq_flush cycle %0d got %b want %b", i, if_flush, (i == 0)); end
         if (i > 0) begin
            checks++; if (pc_four_1 !== a) begin errors++; $display("[TB] FAIL seq_pc4 got %h want %h", pc_four_1, a); end
         end
         sb.push_back({a + 32'd4, instr_of(a)});
         tick();
      end
   endtask

   task automatic test_stall;
      pcwrite = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (bus.imem_req !== 1'b0 || ifwrite !== 1'b0 || if_flush !== 1'b0) begin errors++; $display("[TB] FAIL stall_ctl req/ifwrite/flush got %b%b%b want 000", bus.imem_req, ifwrite, if_flush); end
         checks++; if (pc_four_1 !== 32'h3010 || instr_1 !== instr_of(32'h300C)) begin errors++; $display("[TB] FAIL stall_hold got %h %h want 3010 %h", pc_four_1, instr_1, instr_of(32'h300C)); end
         tick();
      end
      pcwrite = 1'b1;
      @(negedge clk);
      checks++; if (ifwrite !== 1'b1) begin errors++; $display("[TB] FAIL stall_resume ifwrite got %b want 1", ifwrite); end
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3010) begin errors++; $display("[TB] FAIL stall_addr got %b/%h want 1/3010", bus.imem_req, bus.imem_addr); end
      sb.push_back({32'h3014, instr_of(32'h3010)});
      tick();
   endtask

   task automatic test_drain_redirect;
      mem_wait = 3;
      @(negedge clk);
      checks++; if (bus.imem_addr !== 32'h3014 || ifwrite !== 1'b1) begin errors++; $display("[TB] FAIL drn_start addr/ifwrite got %h/%b want 3014/1", bus.imem_addr, ifwrite); end
      tick();
      pcwrite       = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 32'h3100;
      @(negedge clk);
      checks++; if (bus.imem_addr !== 32'h3014) begin errors++; $display("[TB] FAIL drn_br_addr got %h want 3014", bus.imem_addr); end
      checks++; if (if_flush !== 1'b1 || ifwrite !== 1'b0) begin errors++; $display("[TB] FAIL drn_br_ctl flush/ifwrite got %b/%b want 1/0", if_flush, ifwrite); end
      tick();
      branch_taken = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3014) begin errors++; $display("[TB] FAIL drn_hold got %b/%h want 1/3014", bus.imem_req, bus.imem_addr); end
         checks++; if (if_flush !== 1'b0 || ifwrite !== 1'b0) begin errors++; $display("[TB] FAIL drn_ctl flush/ifwrite got %b/%b want 0/0", if_flush, ifwrite); end
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3100) begin errors++; $display("[TB] FAIL drn_new got %b/%h want 1/3100", bus.imem_req, bus.imem_addr); end
         checks++; if (ifwrite !== 1'b0 || if_flush !== 1'b0) begin errors++; $display("[TB] FAIL drn_wait ifwrite/flush got %b/%b want 0/0", ifwrite, if_flush); end
         if (k == 3) sb.push_back({32'h3104, instr_of(32'h3100)});
         tick();
      end
      pcwrite  = 1'b1;
      mem_wait = 0;
      @(negedge clk);
      checks++; if (ifwrite !== 1'b1 || bus.imem_addr !== 32'h3104) begin errors++; $display("[TB] FAIL drn_after ifwrite/addr got %b/%h want 1/3104", ifwrite, bus.imem_addr); end
      sb.push_back({32'h3108, instr_of(32'h3104)});
      tick();
   endtask

   task automatic test_branch_jump_priority;
      branch_taken  = 1'b1;
      branch_target = 32'h3200;
      jump          = 1'b1;
      jump_target   = 32'h3400;
      @(negedge clk);
      checks++; if (if_flush !== 1'b1 || ifwrite !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL prio_ctl flush/ifwrite/req got %b%b%b want 100", if_flush, ifwrite, bus.imem_req); end
      void'(sb.pop_front());
      tick();
      branch_taken = 1'b0;
      jump         = 1'b0;
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3200) begin errors++; $display("[TB] FAIL prio_addr got %b/%h want 1/3200", bus.imem_req, bus.imem_addr); end
      sb.push_back({32'h3204, instr_of(32'h3200)});
      tick();
      @(negedge clk);
      checks++; if (ifwrite !== 1'b1 || bus.imem_addr !== 32'h3204) begin errors++; $display("[TB] FAIL prio_next ifwrite/addr got %b/%h want 1/3204", ifwrite, bus.imem_addr); end
      sb.push_back({32'h3208, instr_of(32'h3204)});
      tick();
   endtask

   task automatic test_wrap;
      jump        = 1'b1;
      jump_target = 32'hFFFF_FFFC;
      @(negedge clk);
      checks++; if (if_flush !== 1'b1) begin errors++; $display("[TB] FAIL wrap_flush got %b want 1", if_flush); end
      void'(sb.pop_front());
      tick();
      jump = 1'b0;
      @(negedge clk);
      checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_addr got %h want fffffffc", bus.imem_addr); end
      sb.push_back({32'h0000_0000, instr_of(32'hFFFF_FFFC)});
      tick();
      @(negedge clk);
      checks++; if (pc_four_1 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc4 got %h want 0", pc_four_1); end
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_next got %b/%h want 1/0", bus.imem_req, bus.imem_addr); end
      sb.push_back({32'h0000_0004, instr_of(32'h0)});
      tick();
   endtask

   task automatic test_reset_in_drain;
      pcwrite     = 1'b0;
      mem_wait    = 3;
      jump        = 1'b1;
      jump_target = 32'h3300;
      @(negedge clk);
      checks++; if (if_flush !== 1'b1) begin errors++; $display("[TB] FAIL rd_flush got %b want 1", if_flush); end
      void'(sb.pop_front());
      tick();
      jump_target = 32'h3500;
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3300) begin errors++; $display("[TB] FAIL rd_req got %b/%h want 1/3300", bus.imem_req, bus.imem_addr); end
      tick();
      jump = 1'b0;
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3300) begin errors++; $display("[TB] FAIL rd_drain got %b/%h want 1/3300", bus.imem_req, bus.imem_addr); end
      tick();
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b0 || ifwrite !== 1'b0 || if_flush !== 1'b0) begin errors++; $display("[TB] FAIL rd_rst req/ifwrite/flush got %b%b%b want 000", bus.imem_req, ifwrite, if_flush); end
      sb.delete();
      tick();
      rst      = 1'b0;
      pcwrite  = 1'b1;
      mem_wait = 0;
      @(negedge clk);
      checks++; if (pc_four_1 !== 32'h0 || instr_1 !== 32'h0) begin errors++; $display("[TB] FAIL rd_regs got %h %h want 0 0", pc_four_1, instr_1); end
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000) begin errors++; $display("[TB] FAIL rd_restart got %b/%h want 1/3000", bus.imem_req, bus.imem_addr); end
      sb.push_back({32'h3004, instr_of(32'h3000)});
      tick();
      @(negedge clk);
      checks++; if (ifwrite !== 1'b1 || bus.imem_addr !== 32'h3004) begin errors++; $display("[TB] FAIL rd_next ifwrite/addr got %b/%h want 1/3004", ifwrite, bus.imem_addr); end
      sb.push_back({32'h3008, instr_of(32'h3004)});
      tick();
   endtask

   task automatic test_align;
`ifdef IF_ALIGN_CHECK_EN
      exp_align = 1'b1;
`else
      exp_align = 1'b0;
`endif
      jump        = 1'b1;
      jump_target = 32'h3006;
      @(negedge clk);
      checks++; if (if_flush !== 1'b1 || align_err !== 1'b0) begin errors++; $display("[TB] FAIL al_redir flush/align got %b/%b want 1/0", if_flush, align_err); end
      void'(sb.pop_front());
      tick();
      jump = 1'b0;
      @(negedge clk);
      checks++; if (bus.imem_addr !== 32'h3004) begin errors++; $display("[TB] FAIL al_addr got %h want 3004", bus.imem_addr); end
      checks++; if (align_err !== exp_align) begin errors++; $display("[TB] FAIL al_flag got %b want %b", align_err, exp_align); end
      sb.push_back({32'h3008, instr_of(32'h3004)});
      tick();
      @(negedge clk);
      checks++; if (align_err !== exp_align) begin errors++; $display("[TB] FAIL al_sticky got %b want %b", align_err, exp_align); end
      checks++; if (ifwrite !== 1'b1) begin errors++; $display("[TB] FAIL al_ifwrite got %b want 1", ifwrite); end
      sb.push_back({32'h300C, instr_of(32'h3008)});
      tick();
      pcwrite = 1'b0;
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before summary");
      $fatal(1, "[TB] watchdog");
   end

   // Test sequence.
   initial begin
      rst           = 1'b1;
      pcwrite       = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      jump          = 1'b0;
      jump_target   = 32'h0;
      exp_align     = 1'b0;
      tick();
      test_reset();
      test_sequential();
      test_stall();
      test_drain_redirect();
      test_branch_jump_priority();
      test_wrap();
      test_reset_in_drain();
      test_align();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
